// File: rtl/surf_matmul4_seq_pkg.sv
// Shared constants, FSM state type and 2x2 tile indexing helpers for surf_matmul4_seq.
// Matrices are 16 elements, row-major, element 0 in the most significant slot.
package surf_pkg;

  localparam int unsigned MAT_ELEMS  = 16;
  localparam int unsigned TILE_ELEMS = 4;
  localparam int unsigned STEP_W     = 3;
  localparam logic [STEP_W-1:0] LAST_STEP = 3'd7;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  // Row-major matrix index of element t (0..3) of tile (p,q).
  function automatic int unsigned tile_elem(input logic p, input logic q, input int unsigned t);
    int unsigned r0;
    int unsigned c0;
    r0 = p ? 2 : 0;
    c0 = q ? 2 : 0;
    return 4 * (r0 + t / 2) + c0 + t % 2;
  endfunction

  // Bit offset of matrix element idx in a packed 16-element matrix.
  function automatic int unsigned mat_lsb(input int unsigned idx, input int unsigned w);
    return (MAT_ELEMS - 1 - idx) * w;
  endfunction

  // Bit offset of tile element t in a packed 4-element tile.
  function automatic int unsigned tile_lsb(input int unsigned t, input int unsigned w);
    return (TILE_ELEMS - 1 - t) * w;
  endfunction

endpackage

// File: rtl/surf_matmul4_seq_if.sv
// Request/result handshake bundle for surf_matmul4_seq.
// master = requester/consumer side, slave = the multiplier.
interface surf_matmul4_seq_if #(
  parameter int unsigned W = 16
) ();
  import surf_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [MAT_ELEMS*W-1:0] a_mat;
  logic [MAT_ELEMS*W-1:0] b_mat;
  logic                   out_valid;
  logic                   out_ready;
  logic [MAT_ELEMS*W-1:0] c_mat;

  modport master (
    output in_valid, a_mat, b_mat, out_ready,
    input  in_ready, out_valid, c_mat
  );

  modport slave (
    input  in_valid, a_mat, b_mat, out_ready,
    output in_ready, out_valid, c_mat
  );

endinterface

// File: rtl/surf_matmul4_seq_surfboard.sv
// Combinational 2x2 tile multiply-add: r = c + a*b, every product and sum truncated to W bits.
module surfboard #(
  parameter int unsigned W      = 16,
  parameter bit          SIGNED = 1'b1
) (
  input  logic [4*W-1:0] a_tile,
  input  logic [4*W-1:0] b_tile,
  input  logic [4*W-1:0] c_tile,
  output logic [4*W-1:0] r_tile
);
  import surf_pkg::*;

  logic [2*W-1:0] prod;
  logic [W-1:0]   sum;

  always_comb begin
    r_tile = '0;
    prod   = '0;
    sum    = '0;
    for (int unsigned r = 0; r < 2; r++) begin
      for (int unsigned c = 0; c < 2; c++) begin
        sum = c_tile[tile_lsb(2*r + c, W) +: W];
        for (int unsigned k = 0; k < 2; k++) begin
          if (SIGNED)
            prod = $signed(a_tile[tile_lsb(2*r + k, W) +: W]) * $signed(b_tile[tile_lsb(2*k + c, W) +: W]);
          else
            prod = a_tile[tile_lsb(2*r + k, W) +: W] * b_tile[tile_lsb(2*k + c, W) +: W];
          sum = sum + prod[W-1:0];
        end
        r_tile[tile_lsb(2*r + c, W) +: W] = sum;
      end
    end
  end

endmodule

// File: rtl/surf_matmul4_seq.sv
// 4x4 matrix product by sequencing one 2x2 surfboard over eight block steps.
// Optional SURF_MATMUL_ACCUM_EN adds c_init, giving C = A*B + c_init.
module surf_matmul4_seq
  import surf_pkg::*;
#(
  parameter int unsigned W      = 16,
  parameter bit          SIGNED = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  surf_matmul4_seq_if.slave       bus,
`ifdef SURF_MATMUL_ACCUM_EN
  input  logic [MAT_ELEMS*W-1:0]  c_init,
`endif
  output logic                    busy
);

  state_t                 state;
  logic [STEP_W-1:0]      step;
  logic [MAT_ELEMS*W-1:0] op_a;
  logic [MAT_ELEMS*W-1:0] op_b;
  logic [MAT_ELEMS*W-1:0] acc;
  logic [MAT_ELEMS*W-1:0] acc_next;
  logic [MAT_ELEMS*W-1:0] acc_init;
  logic [4*W-1:0]         a_tile, b_tile, c_tile, r_tile;
  logic                   ti, tj, tk;

`ifdef SURF_MATMUL_ACCUM_EN
  assign acc_init = c_init;
`else
  assign acc_init = '0;
`endif

  // Step bits select the block product: ACC(i,j) += A(i,k) * B(k,j).
  assign ti = step[2];
  assign tj = step[1];
  assign tk = step[0];

  always_comb begin
    a_tile = '0;
    b_tile = '0;
    c_tile = '0;
    for (int unsigned t = 0; t < TILE_ELEMS; t++) begin
      a_tile[tile_lsb(t, W) +: W] = op_a[mat_lsb(tile_elem(ti, tk, t), W) +: W];
      b_tile[tile_lsb(t, W) +: W] = op_b[mat_lsb(tile_elem(tk, tj, t), W) +: W];
      c_tile[tile_lsb(t, W) +: W] = acc[mat_lsb(tile_elem(ti, tj, t), W) +: W];
    end
  end

  surfboard #(.W(W), .SIGNED(SIGNED)) u_surfboard (
    .a_tile (a_tile),
    .b_tile (b_tile),
    .c_tile (c_tile),
    .r_tile (r_tile)
  );

  always_comb begin
    acc_next = acc;
    for (int unsigned t = 0; t < TILE_ELEMS; t++)
      acc_next[mat_lsb(tile_elem(ti, tj, t), W) +: W] = r_tile[tile_lsb(t, W) +: W];
  end

  assign bus.c_mat = acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      step          <= '0;
      op_a          <= '0;
      op_b          <= '0;
      acc           <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op_a         <= bus.a_mat;
            op_b         <= bus.b_mat;
            acc          <= acc_init;
            step         <= '0;
            state        <= CALC;
            bus.in_ready <= 1'b0;
            busy         <= 1'b1;
          end
        end
        CALC: begin
          acc  <= acc_next;
          step <= step + 3'd1;
          if (step == LAST_STEP) begin
            state         <= DONE;
            bus.out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            busy          <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          bus.in_ready  <= 1'b1;
          bus.out_valid <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule
